// File: rtl/xfire_rbr_pkg.sv
// Shared RBR definitions: digit encodings, converter FSM states and the
// digit-plane split used by the datapath and by rbr_add reference models.
package xfire_rbr_pkg;

  localparam int unsigned RBR_MAX_W = 64;

  typedef enum logic [1:0] {
    RBR_NEG1  = 2'b00,
    RBR_ZERO0 = 2'b01,
    RBR_ZERO1 = 2'b10,
    RBR_POS1  = 2'b11
  } rbr_digit_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } conv_state_e;

  // Returns {A1, A0}: A1 = odd bits (digit MSBs), A0 = even bits (digit LSBs).
  function automatic logic [2*RBR_MAX_W-1:0] rbr_split(input logic [2*RBR_MAX_W-1:0] d);
    logic [RBR_MAX_W-1:0] a1;
    logic [RBR_MAX_W-1:0] a0;
    for (int unsigned i = 0; i < RBR_MAX_W; i++) begin
      a1[i] = d[2*i+1];
      a0[i] = d[2*i];
    end
    return {a1, a0};
  endfunction

endpackage

// File: rtl/rbr_slice_add.sv
// Combinational CHUNK-bit adder with carry in/out, reused once per CONV cycle.
module rbr_slice_add #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/rbr_to_bin.sv
// Serial RBR to two's complement converter: S = A1 + A0 + 1 resolved CHUNK
// digits per cycle, z = S - 2^W, with valid/ready handshakes on both sides.
module rbr_to_bin
  import xfire_rbr_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic           neg,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     z,
  output logic           zero
);

  localparam int unsigned NCH = W / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK == 0 || W % CHUNK != 0 || W > RBR_MAX_W) begin : g_bad_params
    $error("rbr_to_bin: W must be a multiple of CHUNK and at most RBR_MAX_W");
  end

  conv_state_e      state;
  logic [W-1:0]     a1;
  logic [W-1:0]     a0;
  logic [W-1:0]     a1_nx;
  logic [W-1:0]     a0_nx;
  logic [2*W-1:0]   d;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             zacc;
  logic [CHUNK-1:0] sx;
  logic [CHUNK-1:0] sy;
  logic [CHUNK-1:0] s;
  logic             co;
  logic             accept;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    d     = neg ? ~a : a;
    a1_nx = W'(rbr_split((2*RBR_MAX_W)'(d)) >> RBR_MAX_W);
    a0_nx = W'(rbr_split((2*RBR_MAX_W)'(d)));
  end

  always_comb begin
    sx = '0;
    sy = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt == CW'(i)) begin
        sx = a1[i*CHUNK +: CHUNK];
        sy = a0[i*CHUNK +: CHUNK];
      end
    end
  end

  rbr_slice_add #(.CHUNK(CHUNK)) u_slice_add (
    .x  (sx),
    .y  (sy),
    .ci (cy),
    .s  (s),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      z         <= '0;
      zero      <= 1'b0;
      cnt       <= '0;
      cy        <= 1'b0;
      zacc      <= 1'b0;
      a1        <= '0;
      a0        <= '0;
    end else if (accept) begin
      a1        <= a1_nx;
      a0        <= a0_nx;
      cnt       <= '0;
      cy        <= 1'b1;
      zacc      <= 1'b1;
      out_valid <= 1'b0;
      state     <= ST_CONV;
    end else begin
      case (state)
        ST_CONV: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt == CW'(i)) z[i*CHUNK +: CHUNK] <= s;
          end
          cy   <= co;
          zacc <= zacc & (s == '0);
          if (cnt == CW'(NCH - 1)) begin
            // z[W] = ~S[W], so z == 0 needs a final carry of 1 with all sum bits clear.
            z[W]      <= ~co;
            zero      <= zacc & (s == '0) & co;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbr_to_bin.sv
// Self-checking bench for rbr_to_bin (W=8, CHUNK=4): directed corner cases,
// backpressure, mid-conversion reset and randomized traffic against an integer model.
module tb_rbr_to_bin;

  localparam int unsigned W     = 8;
  localparam int unsigned CHUNK = 4;
  localparam int          NRND  = 10000;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           neg       = 1'b0;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] a         = '0;
  logic           in_ready;
  logic           out_valid;
  logic [W:0]     z;
  logic           zero;

  int n_cmp = 0;
  int n_err = 0;

  rbr_to_bin #(.W(W), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Integer value of the operand: sum of digit * 2^i, negated when neg is set.
  function automatic logic [W:0] model_z(input logic [2*W-1:0] av, input logic nv);
    int v;
    logic [1:0] dg;
    v = 0;
    for (int i = 0; i < int'(W); i++) begin
      dg = av[2*i +: 2];
      if (dg == 2'b11) v += (1 << i);
      else if (dg == 2'b00) v -= (1 << i);
    end
    if (nv) v = -v;
    return v[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
  endtask

  task automatic convert(input logic [2*W-1:0] av, input logic nv, input logic [W:0] exp_z,
                         input string tag);
    int lat;
    a = av; neg = nv; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_result(tag, lat);
    check({tag, "_z"}, 32'(z), 32'(exp_z));
    check({tag, "_zm"}, 32'(z), 32'(model_z(av, nv)));
    check({tag, "_zero"}, 32'(zero), 32'(exp_z == '0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic [W:0]     zhold;
    logic [W:0]     e;
    logic [W:0]     qz[$];
    logic [2*W-1:0] a2;
    logic           have;
    int             lat;
    int             sent;
    int             got;
    int             cyc;

    repeat (3) tick();
    check("rst_ovalid", 32'(out_valid), 0);
    check("rst_z", 32'(z), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_irdy", 32'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    convert(16'h0000, 1'b0, 9'h101, "all_neg1");
    convert(16'hFFFF, 1'b0, 9'h0FF, "all_pos1");
    convert(16'hFFFF, 1'b1, 9'h101, "neg_pos1");
    convert(16'h55AA, 1'b0, 9'h000, "mixed_zero");
    convert(16'h5557, 1'b0, 9'h001, "plus_one");
    convert(16'h55AA, 1'b1, 9'h000, "neg_zero");

    // Backpressure: result held, extra in_valid ignored, then same-cycle accept.
    a = 16'h1C3B; neg = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_result("bp1", lat);
    zhold = z;
    check("bp1_z", 32'(z), 32'(model_z(16'h1C3B, 1'b0)));
    a2 = 16'hE2F0;
    a = a2; neg = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_irdy", 32'(in_ready), 0);
      tick();
      check("bp_hold_z", 32'(z), 32'(zhold));
      check("bp_hold_v", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_same_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 0);
    wait_result("bp2", lat);
    check("bp2_z", 32'(z), 32'(model_z(a2, 1'b1)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset after slice 0 of a conversion.
    a = 16'h5557; neg = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_ovalid", 32'(out_valid), 0);
    check("mrst_z", 32'(z), 0);
    check("mrst_zero", 32'(zero), 0);
    check("mrst_irdy", 32'(in_ready), 1);
    rst_n = 1'b1;
    tick();
    convert(16'hA5C3, 1'b1, model_z(16'hA5C3, 1'b1), "post_rst");

    // Random traffic with stalls on both sides.
    have = 1'b0; sent = 0; got = 0; cyc = 0;
    while (got < NRND && cyc < 90000) begin
      tick();
      cyc++;
      if (!have && sent < NRND && $urandom_range(99) < 80) begin
        a    = 16'($urandom);
        neg  = 1'($urandom);
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = ($urandom_range(99) < 75);
      #1;
      if (in_valid && in_ready) begin
        qz.push_back(model_z(a, neg));
        have = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (qz.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          e = qz.pop_front();
          check("rnd_z", 32'(z), 32'(e));
          check("rnd_zero", 32'(zero), 32'(e == '0));
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_count", got, NRND);
    check("rnd_left", qz.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
